// File: rtl/imm_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_pkg : opcodes, format codes and skid-entry type for imm_gen_pipe |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package imm_gen_pkg;

  // Entry fields are sized for the widest legal configuration; the pipe uses the low bits.
  localparam int c_IMM_MAX_W = 64;
  localparam int c_TAG_MAX_W = 64;

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_R    = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [c_IMM_MAX_W-1:0] imm;
    fmt_e                   fmt;
    logic                   illegal;
    logic [31:0]            inst;
    logic [c_TAG_MAX_W-1:0] tag;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_decode : combinational RV32/RV64 immediate and format decoder        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ENABLE_CSR_IMM = 1'b1
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0]      w_opc;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_uimm;

  assign w_opc    = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];

  // RV64 shifts carry a 6-bit shamt and U-immediates sign-extend past bit 31.
  if (XLEN == 64) begin : g_xlen64
    assign w_shamt = XLEN'(inst_i[25:20]);
    assign w_uimm  = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
  end else begin : g_xlen32
    assign w_shamt = XLEN'(inst_i[24:20]);
    assign w_uimm  = {inst_i[31:12], 12'b0};
  end

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b1;
    if (inst_i[1:0] == 2'b11) begin
      illegal_o = 1'b0;
      case (w_opc)
        c_OPC_LOAD, c_OPC_JALR: begin
          fmt_o = FMT_I;
          imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
        end
        c_OPC_OP_IMM: begin
          fmt_o = FMT_I;
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) imm_o = w_shamt;
          else imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
        end
        c_OPC_STORE: begin
          fmt_o = FMT_S;
          imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        end
        c_OPC_BRANCH: begin
          fmt_o = FMT_B;
          imm_o = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
        end
        c_OPC_LUI, c_OPC_AUIPC: begin
          fmt_o = FMT_U;
          imm_o = w_uimm;
        end
        c_OPC_JAL: begin
          fmt_o = FMT_J;
          imm_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};
        end
        c_OPC_SYSTEM: begin
          if (ENABLE_CSR_IMM && (w_funct3 != 3'b000)) begin
            fmt_o = FMT_Z;
            imm_o = XLEN'(inst_i[19:15]);
          end else begin
            fmt_o = FMT_R;
          end
        end
        c_OPC_OP: fmt_o = FMT_R;
        default:  illegal_o = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_pipe : immediate generator stage with valid/ready 2-entry skid   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ENABLE_CSR_IMM = 1'b1,
  parameter int TAG_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          w_new;
  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic            w_illegal;
  logic            w_accept;
  logic            w_deliver;
  logic            w_unused_ok;

  imm_decode #(
    .XLEN           (XLEN),
    .ENABLE_CSR_IMM (ENABLE_CSR_IMM)
  ) u_decode (
    .inst_i    (in_inst),
    .imm_o     (w_imm),
    .fmt_o     (w_fmt),
    .illegal_o (w_illegal)
  );

  always_comb begin
    w_new                  = '0;
    w_new.imm[XLEN-1:0]    = w_imm;
    w_new.fmt              = w_fmt;
    w_new.illegal          = w_illegal;
    w_new.inst             = in_inst;
    w_new.tag[TAG_W-1:0]   = in_tag;
  end

  // Handshake flags depend on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_accept) begin
            out_d   = w_new;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            out_d = w_new;
          end else if (w_accept) begin
            skid_d  = w_new;
            state_d = ST_TWO;
          end else if (w_deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_deliver) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_inst    = out_q.inst;
  assign out_tag     = out_q.tag[TAG_W-1:0];

  // Upper imm/tag bits exist only for the widest configuration.
  assign w_unused_ok = ^out_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_gen_pipe : directed self-checking bench, XLEN=32 and XLEN=64 DUTs |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_inst, out_tag;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_inst64, out_tag64;
  logic [2:0]  out_fmt64;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] delivered_q[$];

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;
  vec_t vecs[16];

  imm_gen_pipe #(.XLEN(32), .ENABLE_CSR_IMM(1'b1), .TAG_W(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .out_inst(out_inst), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .ENABLE_CSR_IMM(1'b1), .TAG_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
    .out_inst(out_inst64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) delivered_q.push_back(out_tag);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    step(); step();
    reset = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_tag} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset32: valid=%b rdy=%b imm=%h fmt=%0d ill=%b inst=%h tag=%h, required 0/1/zeros",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_tag);
    end
    tests_run++;
    if ({out_valid64, in_ready64, out_imm64, out_fmt64, out_illegal64, out_inst64, out_tag64} !==
        {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset64: valid=%b rdy=%b imm=%h fmt=%0d ill=%b, required 0/1/zeros",
               out_valid64, in_ready64, out_imm64, out_fmt64, out_illegal64);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_tag = 32'h100 + 32'(i);
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({out_valid, out_imm, out_fmt, out_illegal, out_inst, out_tag} !==
          {1'b1, vecs[i].imm32, vecs[i].fmt, vecs[i].ill, vecs[i].inst, 32'h100 + 32'(i)}) begin
        tests_failed++;
        $display("FAIL decode32[%0d] inst=%h: got v=%b imm=%h fmt=%0d ill=%b tag=%h, required imm=%h fmt=%0d ill=%b",
                 i, vecs[i].inst, out_valid, out_imm, out_fmt, out_illegal, out_tag,
                 vecs[i].imm32, vecs[i].fmt, vecs[i].ill);
      end
      tests_run++;
      if ({out_valid64, out_imm64, out_fmt64, out_illegal64} !==
          {1'b1, vecs[i].imm64, vecs[i].fmt, vecs[i].ill}) begin
        tests_failed++;
        $display("FAIL decode64[%0d] inst=%h: got v=%b imm=%h fmt=%0d ill=%b, required imm=%h fmt=%0d ill=%b",
                 i, vecs[i].inst, out_valid64, out_imm64, out_fmt64, out_illegal64,
                 vecs[i].imm64, vecs[i].fmt, vecs[i].ill);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    delivered_q.delete();
    in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 32'h200;
    step();
    tests_run++;
    if ({out_valid, out_imm, out_fmt, out_tag} !== {1'b1, 32'hFFFFFFFC, 3'd2, 32'h200}) begin
      tests_failed++;
      $display("FAIL b2b_sw: got v=%b imm=%h fmt=%0d tag=%h, required 1 fffffffc 2 200",
               out_valid, out_imm, out_fmt, out_tag);
    end
    in_inst = 32'hFE000CE3; in_tag = 32'h201;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_imm, out_fmt, out_tag} !== {1'b1, 32'hFFFFFFF8, 3'd3, 32'h201}) begin
      tests_failed++;
      $display("FAIL b2b_beq: got v=%b imm=%h fmt=%0d tag=%h, required 1 fffffff8 3 201",
               out_valid, out_imm, out_fmt, out_tag);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || delivered_q.size() != 2 ||
        delivered_q[0] !== 32'h200 || delivered_q[1] !== 32'h201) begin
      tests_failed++;
      $display("FAIL b2b_order: got valid=%b count=%0d, required valid=0 tags 200,201",
               out_valid, delivered_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic c_taken;
    c_taken   = 1'b0;
    out_ready = 1'b0;
    delivered_q.delete();
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h300;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || out_tag !== 32'h300) begin
      tests_failed++;
      $display("FAIL bp_first: got rdy=%b tag=%h, required rdy=1 tag=300", in_ready, out_tag);
    end
    in_inst = 32'hFE112E23; in_tag = 32'h301;
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_tag !== 32'h300) begin
      tests_failed++;
      $display("FAIL bp_second: got rdy=%b tag=%h, required rdy=0 tag=300", in_ready, out_tag);
    end
    in_inst = 32'h001000EF; in_tag = 32'h302;
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_tag !== 32'h300 || out_imm !== 32'hFFFFFFFF || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_hold: got rdy=%b v=%b tag=%h imm=%h, required rdy=0 v=1 tag=300 imm=ffffffff",
               in_ready, out_valid, out_tag, out_imm);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_rdy_path: in_ready=%b after out_ready rose, required 0", in_ready);
    end
    for (int k = 0; k < 8 && !c_taken; k++) begin
      if (in_ready) c_taken = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8 && out_valid; k++) step();
    tests_run++;
    if (!c_taken || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got third_accepted=%b valid=%b, required 1 and 0", c_taken, out_valid);
    end
    tests_run++;
    if (delivered_q.size() != 3 || delivered_q[0] !== 32'h300 ||
        delivered_q[1] !== 32'h301 || delivered_q[2] !== 32'h302) begin
      tests_failed++;
      $display("FAIL bp_order: got %0d deliveries, required tags 300,301,302 once each",
               delivered_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    delivered_q.delete();
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h400;
    step();
    in_inst = 32'hFE112E23; in_tag = 32'h401;
    step();
    in_inst = 32'h001000EF; in_tag = 32'h402; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_two: got valid=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    step(); step(); step();
    tests_run++;
    if (delivered_q.size() != 0) begin
      tests_failed++;
      $display("FAIL flush_two_drop: got %0d deliveries, required 0", delivered_q.size());
    end
    // Flush in ONE: the same-cycle delivery completes, the same-cycle accept is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h410;
    step();
    in_inst = 32'hFE112E23; in_tag = 32'h411; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_one: got valid=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    step(); step(); step();
    tests_run++;
    if (delivered_q.size() != 1 || delivered_q[0] !== 32'h410) begin
      tests_failed++;
      $display("FAIL flush_one_deliver: got %0d deliveries, required only tag 410",
               delivered_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h800002B7; in_tag = 32'h500;
    step();
    in_inst = 32'h001000EF; in_tag = 32'h501;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    delivered_q.delete();
    tests_run++;
    if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_tag} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid32: valid=%b rdy=%b imm=%h fmt=%0d ill=%b inst=%h tag=%h, required 0/1/zeros",
               out_valid, in_ready, out_imm, out_fmt, out_illegal, out_inst, out_tag);
    end
    tests_run++;
    if ({out_valid64, out_imm64, out_inst64, out_tag64} !== {1'b0, 64'h0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid64: valid=%b imm=%h, required 0 0", out_valid64, out_imm64);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h510;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_imm, out_fmt, out_tag} !== {1'b1, 32'hFFFFFFFF, 3'd1, 32'h510}) begin
      tests_failed++;
      $display("FAIL reset_restart: got v=%b imm=%h fmt=%0d tag=%h, required 1 ffffffff 1 510",
               out_valid, out_imm, out_fmt, out_tag);
    end
    step(); step();
    tests_run++;
    if (delivered_q.size() != 1 || delivered_q[0] !== 32'h510) begin
      tests_failed++;
      $display("FAIL reset_discard: got %0d deliveries, required only tag 510", delivered_q.size());
    end
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0}; // addi -1
    vecs[1]  = '{32'hFFF12083, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0}; // lw -1
    vecs[2]  = '{32'h7FF100E7, 32'h000007FF, 64'h00000000_000007FF, 3'd1, 1'b0}; // jalr 0x7ff
    vecs[3]  = '{32'h02009093, 32'h00000000, 64'h00000000_00000020, 3'd1, 1'b0}; // slli 32
    vecs[4]  = '{32'h4010D093, 32'h00000001, 64'h00000000_00000001, 3'd1, 1'b0}; // srai 1
    vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0}; // sw -4
    vecs[6]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0}; // beq -8
    vecs[7]  = '{32'h001000EF, 32'h00000800, 64'h00000000_00000800, 3'd5, 1'b0}; // jal 0x800
    vecs[8]  = '{32'h800002B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0}; // lui
    vecs[9]  = '{32'h12345297, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0}; // auipc
    vecs[10] = '{32'h3002D073, 32'h00000005, 64'h00000000_00000005, 3'd6, 1'b0}; // csrrwi 5
    vecs[11] = '{32'h00000073, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b0}; // ecall
    vecs[12] = '{32'h002081B3, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b0}; // add
    vecs[13] = '{32'h00000000, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1}; // zero word
    vecs[14] = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1}; // bad opcode
    vecs[15] = '{32'hFFF00091, 32'h00000000, 64'h00000000_00000000, 3'd0, 1'b1}; // low bits 01

    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the RV32/RV64 decode stage. It covers every base immediate format (I, S, B, U, J) plus CSR zimm, and flags opcodes it does not recognise. It sits between fetch and the register-read/ALU stage. Both sides use a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all immediates are extended to XLEN.
ENABLE_CSR_IMM, 1, 1 = decode SYSTEM funct3!=0 as Z format; 0 = treat it as R (imm 0).
TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream has an instruction
in_ready  out  1  block can accept an instruction
in_inst  in  32  instruction word
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output holds a valid result
out_ready  in  1  downstream accepts the result
out_imm  out  XLEN  extended immediate
out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 R
out_illegal  out  1  unrecognised opcode, or inst[1:0]!=2'b11
out_inst  out  32  pass-through instruction word
out_tag  out  TAG_W  pass-through tag

Behaviour:
- Handshake:
  - Accept when in_valid & in_ready.
  - Deliver when out_valid & out_ready.
  - out_* must hold stable while out_valid & !out_ready.
- Latency: 1 cycle from accept to out_valid, provided the block was empty or draining.
- State machine on the number of occupied entries:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & deliver -> ONE (the output register reloads).
    - Accept & !deliver -> TWO (the new entry goes into the skid register).
    - Deliver only -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Deliver -> ONE (the skid entry moves to the output register).
- in_ready is registered: it is driven from state only, with no combinational path from out_ready.
- Decode runs combinationally on in_inst; the decoded result is stored in the entry.
- Opcode to format mapping:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR -> I: sign-extend inst[31:20].
    - OP-IMM with funct3 001/101 (shifts): zero-extend shamt. XLEN=32 uses inst[24:20]; XLEN=64 uses inst[25:20].
  - 0100011 STORE -> S: sext{inst[31:25], inst[11:7]}.
  - 1100011 BRANCH -> B: sext{inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111 LUI, 0010111 AUIPC -> U: {inst[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 1101111 JAL -> J: sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 1110011 SYSTEM with funct3!=0 and ENABLE_CSR_IMM=1 -> Z: zero-extend inst[19:15].
  - 0110011 OP, and SYSTEM funct3==0 -> R: imm 0, illegal 0.
  - Any other opcode, or inst[1:0]!=11 -> NONE: imm 0, illegal 1.
- Illegal instructions still flow through the pipe; the block never stalls on them.
- flush:
  - Next cycle: state EMPTY, out_valid=0, in_ready=1.
  - A handshake accepted in the same cycle as flush is discarded.
  - A deliver in the same cycle as flush counts as completed.
- reset: same effect as flush, and also clears all registers. After reset, out_imm, out_inst and out_tag are 0; out_fmt=0 and out_illegal=0. Reset asserted mid-transfer discards all held entries.
- reset has priority over flush, and flush has priority over accept.
- No reordering, no loss, no duplication under any pattern of out_ready.

Decomposition:
- Package imm_gen_pkg holds:
  - the opcode localparams;
  - the fmt enum constants (NONE..R);
  - the decoded-entry struct {imm, fmt, illegal, inst, tag}.
- Sub-module imm_decode holds the purely combinational decode (inst -> imm/fmt/illegal, parametrised by XLEN and ENABLE_CSR_IMM).
- The top level holds the skid buffer and the state machine.

Test Plan:
- ADDI 0xFFF00093, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- SW 0xFE112E23, then BEQ 0xFE000CE3, back-to-back -> 0xFFFFFFFC (fmt 2), then 0xFFFFFFF8 (fmt 3), on consecutive cycles.
- JAL 0x001000EF -> 0x00000800, fmt 5.
- LUI 0x800002B7 with XLEN=64 -> 0xFFFFFFFF80000000, fmt 4.
- Invalid word 0x00000000 -> imm 0, fmt 0, illegal 1.
- Backpressure: three back-to-back valids with out_ready=0 for 3 cycles -> in_ready drops after the second accept; all three delivered in order, each exactly once.
- flush in state TWO, with in_valid=1 that cycle -> out_valid=0 next cycle, in_ready=1, the offered instruction is not delivered.
- reset pulsed mid-stream -> outputs return to their reset values (out_valid=0, all data outputs 0); after release the first new instruction appears 1 cycle after accept.
